bitrev_output_buffer: RTL and testbench

Ping-pong reorder buffer at the output of the in-place radix-2 FFT core. The core emits result frames of N = 2^ADDR_WIDTH samples in bit-reversed index order. This block writes each incoming sample at the bit-reversed address, then streams the frame out in natural order. It is the read-side counterpart of the core's address bit-swap, and has valid/ready handshakes on both sides, so one frame can be written while the previous frame drains.

---
 rtl/bitrev_output_buffer.sv | 134 +++++++++++++
 tb/tb_bitrev_output_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_output_buffer.sv
// Ping-pong reorder buffer: bit-reversed FFT frames in, natural order out.
// Define BITREV_BYPASS_EN to add a per-frame `bypass` port (natural-order write).
module bitrev_output_buffer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef BITREV_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last
);

  localparam int N = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  logic [DATA_WIDTH-1:0] mem [2][N];

  logic       wbank;
  logic       rbank;
  addr_t      wcnt;
  addr_t      rcnt;
  logic [1:0] full;
  logic [1:0] full_d;

  logic  in_fire;
  logic  out_fire;
  logic  wr_last;
  logic  rd_last;
  addr_t waddr;

  function automatic addr_t bitrev(input addr_t x);
    addr_t r;
    r = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      r[i] = x[ADDR_WIDTH-1-i];
    end
    return r;
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign wr_last  = in_fire && (wcnt == '1);
  assign rd_last  = out_fire && (rcnt == '1);

`ifdef BITREV_BYPASS_EN
  logic byp_q;
  logic byp_eff;

  // First sample of a frame uses the live pin; the rest use the held copy.
  assign byp_eff = (wcnt == '0) ? bypass : byp_q;
  assign waddr   = byp_eff ? wcnt : bitrev(wcnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q <= 1'b0;
    end else if (in_fire && (wcnt == '0)) begin
      byp_q <= bypass;
    end
  end
`else
  assign waddr = bitrev(wcnt);
`endif

  // Sample storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wbank][waddr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank <= 1'b0;
      wcnt  <= '0;
    end else if (in_fire) begin
      wcnt <= wcnt + 1'b1;
      if (wr_last) begin
        wbank <= ~wbank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbank <= 1'b0;
      rcnt  <= '0;
    end else if (out_fire) begin
      rcnt <= rcnt + 1'b1;
      if (rd_last) begin
        rbank <= ~rbank;
      end
    end
  end

  // Per-bank EMPTY/FULL state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      full <= full_d;
    end
  end

  // Write and read always target different banks, so both updates apply.
  always_comb begin
    full_d = full;
    if (wr_last) begin
      full_d[wbank] = 1'b1;
    end
    if (rd_last) begin
      full_d[rbank] = 1'b0;
    end
  end

  always_comb begin
    in_ready  = !full[wbank];
    out_valid = full[rbank];
    out_last  = full[rbank] && (rcnt == '1);
  end

  assign out_data = mem[rbank][rcnt];
  assign out_idx  = rcnt;

endmodule

// File: tb/tb_bitrev_output_buffer.sv
// Scoreboard bench for bitrev_output_buffer.
// Reference model reorders whole frames with plain array arithmetic.
module tb_bitrev_output_buffer;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
`ifdef BITREV_BYPASS_EN
  logic          bypass;
`endif

  bitrev_output_buffer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef BITREV_BYPASS_EN
    .bypass   (bypass),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] frame_q[$];
  logic        frame_byp;
  logic        byp_drive;

  int n_chk;
  int n_fail;
  int cyc;
  int rdy_mode;
  int stalls;
  int last_fire_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int brev(input int x);
    int r;
    r = 0;
    for (int i = 0; i < AW; i++) begin
      r = r + (((x >> i) & 1) << (AW - 1 - i));
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: k-th input of a frame lands at natural index brev(k).
  task automatic model_accept(input logic [31:0] d);
    int src;
    exp_t e;
    if (frame_q.size() == 0) frame_byp = byp_drive;
    frame_q.push_back(d);
    if (frame_q.size() == N) begin
      for (int j = 0; j < N; j++) begin
        src    = frame_byp ? j : brev(j);
        e.idx  = j;
        e.data = frame_q[src];
        e.last = (j == N - 1);
        exp_q.push_back(e);
      end
      frame_q.delete();
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
`ifdef BITREV_BYPASS_EN
    bypass = byp_drive;
`endif
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (n >= 1000) begin
      chk("send_timeout", 64'(n), 64'd0);
      in_valid = 1'b0;
    end else begin
      model_accept(d);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: picks out_ready, checks stability and pops the scoreboard.
  initial begin : monitor
    logic        hold;
    logic [38:0] saved;
    exp_t        e;
    hold = 1'b0;
    saved = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("stable", {out_valid, out_last, out_idx, out_data}, 64'(saved));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'(out_idx), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("out", {out_last, out_idx, out_data},
                {e.last, 5'(e.idx), e.data});
          end
          if (out_last) last_fire_cyc = cyc + 1;
        end
        hold  = out_valid && !out_ready;
        saved = {out_valid, out_last, out_idx, out_data};
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic ok;
    int   n;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    stalls = 0;
    rdy_mode = 1;
    last_fire_cyc = -1;
    byp_drive = 1'b0;
    frame_byp = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
`ifdef BITREV_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);

    // Frame of k, check first-valid latency
    for (int k = 0; k < N - 1; k++) send(32'(k));
    chk("pre_valid", 64'(out_valid), 64'd0);
    send(32'(N - 1));
    chk("pre_valid_last", 64'(out_valid), 64'd0);
    idle();
    chk("latency_valid", 64'(out_valid), 64'd1);
    drain();

    // Three frames against a blocked output
    rdy_mode = 0;
    for (int k = 0; k < 2 * N; k++) send($urandom);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h5555_0000;
    ok = 1'b1;
    repeat (20) begin
      if (in_ready) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_both_full", 64'(ok), 64'd1);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    rdy_mode = 1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("ready_return_cyc", 64'(cyc), 64'(last_fire_cyc));
    for (int k = 0; k < N; k++) send(32'h5555_0000 + 32'(k));
    idle();
    drain();

    // Continuous traffic, four frames
    stalls = 0;
    for (int k = 0; k < 4 * N; k++) send($urandom);
    idle();
    chk("continuous_stalls", 64'(stalls), 64'd0);
    drain();

    // Random output backpressure
    rdy_mode = 2;
    for (int k = 0; k < 3 * N; k++) begin
      send($urandom);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    drain();
    rdy_mode = 1;

    // Reset mid-frame
    for (int k = 0; k < 10; k++) send($urandom);
    idle();
    rst_n = 1'b0;
    frame_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) send(32'hA000_0000 + 32'(k));
    idle();
    drain();

`ifdef BITREV_BYPASS_EN
    // Bypass frame (pin wiggles after sample 0), then a normal frame
    for (int k = 0; k < N; k++) begin
      byp_drive = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      send(32'(k));
    end
    for (int k = 0; k < N; k++) begin
      byp_drive = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      send(32'(k));
    end
    byp_drive = 1'b0;
    idle();
    drain();
`endif

    repeat (40) @(negedge clk);
    chk("final_no_valid", 64'(out_valid), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
